// File: rtl/energy_frame_detector_if.sv
// energy_frame_detector_if: squared-magnitude bin stream in, per-bin and per-frame detection results out
// master drives dv_sq_m/xk_sq_m/sof/thresh/min_hits and observes the results; slave is the detector
interface energy_frame_detector_if #(
  parameter int IDX_W = 10,
  parameter int ACC_W = 42
);
  logic             dv_sq_m;
  logic [31:0]      xk_sq_m;
  logic             sof;
  logic [31:0]      thresh;
  logic [IDX_W:0]   min_hits;
  logic             bin_hit;
  logic [IDX_W-1:0] bin_idx;
  logic             dv_hit;
  logic             frame_valid;
  logic [ACC_W-1:0] frame_energy;
  logic [IDX_W:0]   hit_count;
  logic             detect;
  logic             frame_err;
  modport master (
    output dv_sq_m, xk_sq_m, sof, thresh, min_hits,
    input  bin_hit, bin_idx, dv_hit, frame_valid, frame_energy, hit_count, detect, frame_err
  );
  modport slave (
    input  dv_sq_m, xk_sq_m, sof, thresh, min_hits,
    output bin_hit, bin_idx, dv_hit, frame_valid, frame_energy, hit_count, detect, frame_err
  );
endinterface

// File: rtl/energy_frame_detector.sv
// energy_frame_detector: per-bin threshold compare, frame energy/hit accumulation and per-frame detect decision
// clock/reset (async, active-low); s: bin stream in (dv_sq_m, xk_sq_m, sof, thresh, min_hits),
// per-bin out (dv_hit, bin_hit, bin_idx), per-frame out (frame_valid, frame_energy, hit_count, detect, frame_err)
module energy_frame_detector #(
  parameter int FFT_LEN = 1024,
  parameter int IDX_W   = 10,
  parameter int ACC_W   = 42
) (
  input logic clock,
  input logic reset,
  energy_frame_detector_if.slave s
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state;
  logic [IDX_W-1:0] idx, cur_idx;
  logic [31:0] thresh_l, thr;
  logic [IDX_W:0] min_hits_l, min_cur, hits, hits_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic accept, first, last, hit_c;
  // bin 0 (sof or idx wrap) uses the live thresh/min_hits and restarts the sums instead of adding
  always_comb begin
    accept  = s.dv_sq_m & (s.sof | (state == ACC));
    cur_idx = s.sof ? '0 : idx;
    first   = accept & (cur_idx == '0);
    last    = accept & (cur_idx == IDX_W'(FFT_LEN - 1));
    thr     = first ? s.thresh : thresh_l;
    min_cur = first ? s.min_hits : min_hits_l;
    hit_c   = s.xk_sq_m > thr;
    acc_n   = (first ? '0 : acc) + ACC_W'(s.xk_sq_m);
    hits_n  = (first ? '0 : hits) + (IDX_W+1)'(hit_c);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      thresh_l       <= '0;
      min_hits_l     <= '0;
      acc            <= '0;
      hits           <= '0;
      s.dv_hit       <= 1'b0;
      s.bin_hit      <= 1'b0;
      s.bin_idx      <= '0;
      s.frame_valid  <= 1'b0;
      s.frame_err    <= 1'b0;
      s.frame_energy <= '0;
      s.hit_count    <= '0;
      s.detect       <= 1'b0;
    end else begin
      s.dv_hit      <= accept;
      s.bin_hit     <= accept & hit_c;
      s.frame_valid <= last;
      s.frame_err   <= s.dv_sq_m & s.sof & (state == ACC) & (idx != '0);
      if (accept) begin
        state     <= ACC;
        idx       <= cur_idx + IDX_W'(1);
        s.bin_idx <= cur_idx;
        acc       <= acc_n;
        hits      <= hits_n;
      end
      if (first) begin
        thresh_l   <= s.thresh;
        min_hits_l <= s.min_hits;
      end
      if (last) begin
        s.frame_energy <= acc_n;
        s.hit_count    <= hits_n;
        s.detect       <= hits_n >= min_cur;
      end
    end
endmodule
